// File: rtl/wb_pkg.sv
// Shared types for the data-cache posted write buffer: FSM states, default
// widths and the buffer entry layout.
package wb_pkg;

    localparam int WB_ADDR_W = 28;
    localparam int WB_LINE_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        READ,
        RESP
    } wb_state_e;

    typedef struct packed {
        logic                 valid;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_LINE_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/dcache_write_buffer_if.sv
// Cache-side and memory-side line buses of the write buffer.
// The buffer is the slave toward the cache and drives the memory request.
interface dcache_write_buffer_if #(
    parameter int ADDR_W = wb_pkg::WB_ADDR_W,
    parameter int LINE_W = wb_pkg::WB_LINE_W
);
    logic              cache_read;
    logic              cache_write;
    logic [ADDR_W-1:0] cache_addr;
    logic [LINE_W-1:0] cache_wdata;
    logic [LINE_W-1:0] cache_rdata;
    logic              cache_ready;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              wb_empty;

    modport slave (
        input  cache_read, cache_write, cache_addr, cache_wdata, mem_rdata, mem_ready,
        output cache_rdata, cache_ready, mem_read, mem_write, mem_addr, mem_wdata, wb_empty
    );

    modport master (
        output cache_read, cache_write, cache_addr, cache_wdata, mem_rdata, mem_ready,
        input  cache_rdata, cache_ready, mem_read, mem_write, mem_addr, mem_wdata, wb_empty
    );
endinterface

// File: rtl/wb_line_store.sv
// Circular line store with CAM lookup: returns the youngest matching entry
// for reads and a coalesce target for writes.
module wb_line_store import wb_pkg::*; #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enq,
    input  logic [WB_ADDR_W-1:0] enq_addr,
    input  logic [WB_LINE_W-1:0] wdata,
    input  logic                 coal,
    input  logic [PTR_W-1:0]     coal_idx,
    input  logic                 pop,
    input  logic [WB_ADDR_W-1:0] lkup_addr,
    input  logic                 excl_head,
    output logic                 rd_hit,
    output logic [WB_LINE_W-1:0] rd_data,
    output logic                 wr_hit,
    output logic [PTR_W-1:0]     wr_idx,
    output logic [WB_ADDR_W-1:0] head_addr,
    output logic [WB_LINE_W-1:0] head_data,
    output logic [CNT_W-1:0]     count
);
    wb_entry_t        ents [DEPTH];
    logic [PTR_W-1:0] head, tail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ents[i] <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                ents[head].valid <= 1'b0;
                head             <= head + PTR_W'(1);
            end
            if (enq) begin
                ents[tail] <= '{valid: 1'b1, addr: enq_addr, data: wdata};
                tail       <= tail + PTR_W'(1);
            end
            if (coal) ents[coal_idx].data <= wdata;
            count <= count + CNT_W'(enq) - CNT_W'(pop);
        end
    end

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        wr_hit  = 1'b0;
        wr_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            automatic logic [PTR_W-1:0] idx = head + PTR_W'(k);
            if (ents[idx].valid && ents[idx].addr == lkup_addr) begin
                rd_hit  = 1'b1;
                rd_data = ents[idx].data;
                if (!(excl_head && k == 0)) begin
                    wr_hit = 1'b1;
                    wr_idx = idx;
                end
            end
        end
    end

    assign head_addr = ents[head].addr;
    assign head_data = ents[head].data;

endmodule

// File: rtl/dcache_write_buffer.sv
// Posted write buffer between the data cache and slow memory: acks line
// writes in one cycle, drains them in order, and serves read hits locally.
module dcache_write_buffer import wb_pkg::*; #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int LINE_W = WB_LINE_W
) (
    input logic                  clk,
    input logic                  rst_n,
    dcache_write_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_state_e         state, state_nx;
    logic              cache_ready_q, mem_read_q, mem_write_q;
    logic [LINE_W-1:0] cache_rdata_q, mem_wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              req_ok, rd_req, wr_req, rd_miss;
    logic              rd_hit, wr_hit, enq, coal, pop, excl_head;
    logic [PTR_W-1:0]  wr_idx;
    logic [CNT_W-1:0]  count;
    logic [LINE_W-1:0] rd_data, head_data;
    logic [ADDR_W-1:0] head_addr;

    // The cache keeps its request up during the ack cycle, so ignore it then.
    assign req_ok  = !cache_ready_q && (state == IDLE || state == DRAIN);
    assign rd_req  = req_ok && bus.cache_read;
    assign wr_req  = req_ok && bus.cache_write;
    assign rd_miss = rd_req && !rd_hit;

    // The head is being (or about to be) copied to memory; never modify it.
    assign excl_head = (state == DRAIN) || (state_nx == DRAIN);
    assign coal      = wr_req && wr_hit;
    assign enq       = wr_req && !wr_hit && (count < CNT_W'(DEPTH));
    assign pop       = (state == DRAIN) && bus.mem_ready;

    wb_line_store #(.DEPTH(DEPTH)) u_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .enq       (enq),
        .enq_addr  (bus.cache_addr),
        .wdata     (bus.cache_wdata),
        .coal      (coal),
        .coal_idx  (wr_idx),
        .pop       (pop),
        .lkup_addr (bus.cache_addr),
        .excl_head (excl_head),
        .rd_hit    (rd_hit),
        .rd_data   (rd_data),
        .wr_hit    (wr_hit),
        .wr_idx    (wr_idx),
        .head_addr (head_addr),
        .head_data (head_data),
        .count     (count)
    );

    // A read miss waiting in IDLE takes priority over the next drain.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (rd_miss)            state_nx = READ;
                else if (count != '0)   state_nx = DRAIN;
            end
            DRAIN:   if (bus.mem_ready) state_nx = IDLE;
            READ:    if (bus.mem_ready) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cache_ready_q <= 1'b0;
            cache_rdata_q <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            state         <= state_nx;
            cache_ready_q <= coal || enq || (rd_req && rd_hit) || (state == RESP);

            if (rd_req && rd_hit)
                cache_rdata_q <= rd_data;
            else if (state == READ && bus.mem_ready)
                cache_rdata_q <= bus.mem_rdata;

            if (state == IDLE && state_nx == READ) begin
                mem_read_q <= 1'b1;
                mem_addr_q <= bus.cache_addr;
            end else if (state == IDLE && state_nx == DRAIN) begin
                mem_write_q <= 1'b1;
                mem_addr_q  <= head_addr;
                mem_wdata_q <= head_data;
            end

            if (pop)                          mem_write_q <= 1'b0;
            if (state == READ && bus.mem_ready) mem_read_q <= 1'b0;
        end
    end

    assign bus.cache_ready = cache_ready_q;
    assign bus.cache_rdata = cache_rdata_q;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.wb_empty    = (count == '0);

endmodule
